// File: rtl/fios_pkg.sv
// Shared widths, DSP OPMODE encodings, FSM state and bus payload types
// for the FIOS processing-element sequencer.
package fios_pkg;

  localparam int unsigned WORD_W   = 17;
  localparam int unsigned P_W      = 34;
  localparam int unsigned OPMODE_W = 9;

  localparam logic [OPMODE_W-1:0] ZERO  = 9'b00_000_00_00;
  localparam logic [OPMODE_W-1:0] FIRST = 9'b11_000_01_01;
  localparam logic [OPMODE_W-1:0] ACC   = 9'b11_110_01_01;
  localparam logic [OPMODE_W-1:0] HOLD  = 9'b00_000_00_10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fios_state_e;

  typedef struct packed {
    logic                creg_en;
    logic [OPMODE_W-1:0] opmode;
    logic [WORD_W-1:0]   c_word;
  } fios_ctrl_t;

  typedef struct packed {
    logic valid;
    logic last;
  } fios_tag_t;

endpackage

// File: rtl/fios_delay_line.sv
// Fixed-latency shift register with synchronous active-high clear.
// DEPTH of 0 degenerates to a plain wire.
module fios_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    assign dout = din;
  end else begin : g_regs
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/fios_pe_seq.sv
// Row sequencer driving a pipelined DSP slice for one FIOS multiply-accumulate row.
// Define FIOS_PE_SEQ_ASSERT_EN to compile in protocol assertions.
module fios_pe_seq
  import fios_pkg::*;
#(
  parameter int unsigned ABREG      = 1,
  parameter int unsigned MREG       = 1,
  parameter int unsigned WORD_COUNT = 4
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [WORD_W-1:0]   a_word_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [WORD_W-1:0]   b_word_i,
  input  logic [WORD_W-1:0]   c_word_i,
  output logic [WORD_W-1:0]   A_o,
  output logic [WORD_W-1:0]   B_o,
  output logic [P_W-1:0]      C_o,
  output logic [OPMODE_W-1:0] OPMODE_o,
  output logic                CREG_en_o,
  input  logic [P_W-1:0]      P_i,
  output logic                res_valid_o,
  output logic [WORD_W-1:0]   res_word_o,
  output logic                res_last_o,
  output logic [WORD_W-1:0]   res_carry_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int unsigned DSP_REG_LEVEL = 1 + ABREG + MREG;
  localparam int unsigned CTRL_DLY      = ABREG + MREG - 1;
  localparam int unsigned CNT_W         = $clog2(WORD_COUNT + 1);

  fios_state_e        state;
  logic [CNT_W-1:0]   issue_cnt;
  logic [WORD_W-1:0]  a_q;
  logic               ready_q;
  logic               busy_q;
  logic               issue;
  logic               issue_last;
  fios_ctrl_t         ctrl_in;
  fios_ctrl_t         ctrl_dly;
  fios_tag_t          tag_in;
  fios_tag_t          tag_dly;

  assign issue      = in_valid_i & ready_q;
  assign issue_last = issue & (issue_cnt == CNT_W'(WORD_COUNT - 1));

  // Row FSM; ready/busy are registered alongside the state
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state     <= IDLE;
      issue_cnt <= '0;
      a_q       <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state     <= RUN;
            issue_cnt <= '0;
            a_q       <= a_word_i;
            ready_q   <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        RUN: begin
          if (issue) begin
            issue_cnt <= issue_cnt + CNT_W'(1);
            if (issue_last) begin
              state   <= DRAIN;
              ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (tag_dly.valid && tag_dly.last) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Bubbles hold P so the running carry survives a stall
  always_comb begin
    ctrl_in = '{creg_en: 1'b0, opmode: ZERO, c_word: '0};
    if (issue) begin
      ctrl_in.creg_en = 1'b1;
      ctrl_in.opmode  = (issue_cnt == '0) ? FIRST : ACC;
      ctrl_in.c_word  = c_word_i;
    end else if (state != IDLE) begin
      ctrl_in.opmode  = HOLD;
    end
  end

  assign tag_in = '{valid: issue, last: issue_last};

  fios_delay_line #(
    .DEPTH (CTRL_DLY),
    .WIDTH ($bits(fios_ctrl_t))
  ) u_ctrl_dly (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .din     (ctrl_in),
    .dout    (ctrl_dly)
  );

  fios_delay_line #(
    .DEPTH (DSP_REG_LEVEL),
    .WIDTH ($bits(fios_tag_t))
  ) u_res_dly (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .din     (tag_in),
    .dout    (tag_dly)
  );

  assign in_ready_o = ready_q;
  assign busy_o     = busy_q;
  assign A_o        = issue ? a_q : '0;
  assign B_o        = issue ? b_word_i : '0;

  // Trailing HOLD slots from the drain are masked once the row is closed
  assign OPMODE_o   = (state == IDLE) ? ZERO : ctrl_dly.opmode;
  assign CREG_en_o  = (state != IDLE) & ctrl_dly.creg_en;
  assign C_o        = (state == IDLE) ? '0 : P_W'(ctrl_dly.c_word);

  assign res_valid_o = tag_dly.valid;
  assign res_last_o  = tag_dly.valid & tag_dly.last;
  assign done_o      = tag_dly.valid & tag_dly.last;
  assign res_word_o  = tag_dly.valid ? P_i[WORD_W-1:0] : '0;
  assign res_carry_o = (tag_dly.valid && tag_dly.last) ? P_i[P_W-1:WORD_W] : '0;

`ifdef FIOS_PE_SEQ_ASSERT_EN
  logic [CNT_W-1:0] res_cnt;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      res_cnt <= '0;
    end else begin
      if (res_valid_o) res_cnt <= res_last_o ? '0 : res_cnt + CNT_W'(1);
      assert (OPMODE_o == ZERO || OPMODE_o == FIRST || OPMODE_o == ACC || OPMODE_o == HOLD);
      assert (!res_valid_o || res_cnt < CNT_W'(WORD_COUNT));
      assert (!res_last_o || res_cnt == CNT_W'(WORD_COUNT - 1));
      assert (!res_valid_o || res_last_o || res_cnt != CNT_W'(WORD_COUNT - 1));
      assert (!in_ready_o || state == RUN);
    end
  end
`endif

endmodule

// File: tb/tb_fios_pe_seq.sv
// Bench for fios_pe_seq: two instances (ABREG=1/MREG=1 and ABREG=2/MREG=0),
// each paired with a behavioural DSP slice, checked against one scoreboard.
module tb_fios_pe_seq;

  localparam int NI = 2;
  localparam int WC = 4;
  localparam int LAT = 3;
  localparam logic [8:0] OP_ZERO  = 9'b000000000;
  localparam logic [8:0] OP_FIRST = 9'b110000101;
  localparam logic [8:0] OP_ACC   = 9'b111100101;
  localparam logic [8:0] OP_HOLD  = 9'b000000010;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic [16:0] a_word_i = '0;
  logic        in_valid_i = 1'b0;
  logic [16:0] b_word_i = '0;
  logic [16:0] c_word_i = '0;

  logic        in_ready_o [NI];
  logic [16:0] A_o [NI];
  logic [16:0] B_o [NI];
  logic [33:0] C_o [NI];
  logic [8:0]  OPMODE_o [NI];
  logic        CREG_en_o [NI];
  logic [33:0] P_i [NI];
  logic        res_valid_o [NI];
  logic [16:0] res_word_o [NI];
  logic        res_last_o [NI];
  logic [16:0] res_carry_o [NI];
  logic        busy_o [NI];
  logic        done_o [NI];

  always #5 clock_i = ~clock_i;

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int unsigned AB = (g == 0) ? 1 : 2;
    localparam int unsigned MR = (g == 0) ? 1 : 0;

    fios_pe_seq #(.ABREG(AB), .MREG(MR), .WORD_COUNT(WC)) u_dut (
      .clock_i     (clock_i),
      .reset_i     (reset_i),
      .start_i     (start_i),
      .a_word_i    (a_word_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o[g]),
      .b_word_i    (b_word_i),
      .c_word_i    (c_word_i),
      .A_o         (A_o[g]),
      .B_o         (B_o[g]),
      .C_o         (C_o[g]),
      .OPMODE_o    (OPMODE_o[g]),
      .CREG_en_o   (CREG_en_o[g]),
      .P_i         (P_i[g]),
      .res_valid_o (res_valid_o[g]),
      .res_word_o  (res_word_o[g]),
      .res_last_o  (res_last_o[g]),
      .res_carry_o (res_carry_o[g]),
      .busy_o      (busy_o[g]),
      .done_o      (done_o[g])
    );

    // DSP slice: AB input regs, optional M reg, C/OPMODE regs, P reg
    logic [16:0] a_pipe [AB];
    logic [16:0] b_pipe [AB];
    logic [33:0] m_val, c_r, p_r;
    logic [8:0]  op_r;

    always @(posedge clock_i) begin
      if (reset_i) begin
        for (int i = 0; i < int'(AB); i++) begin
          a_pipe[i] <= '0;
          b_pipe[i] <= '0;
        end
        c_r  <= '0;
        p_r  <= '0;
        op_r <= '0;
      end else begin
        a_pipe[0] <= A_o[g];
        b_pipe[0] <= B_o[g];
        for (int i = 1; i < int'(AB); i++) begin
          a_pipe[i] <= a_pipe[i-1];
          b_pipe[i] <= b_pipe[i-1];
        end
        if (CREG_en_o[g]) c_r <= C_o[g];
        op_r <= OPMODE_o[g];
        case (op_r)
          OP_FIRST: p_r <= m_val + c_r;
          OP_ACC:   p_r <= m_val + c_r + (p_r >> 17);
          OP_HOLD:  p_r <= p_r;
          default:  p_r <= '0;
        endcase
      end
    end

    if (MR == 1) begin : g_mreg
      logic [33:0] m_q;
      always @(posedge clock_i) begin
        if (reset_i) m_q <= '0;
        else         m_q <= 34'(a_pipe[AB-1]) * 34'(b_pipe[AB-1]);
      end
      assign m_val = m_q;
    end else begin : g_nomreg
      assign m_val = 34'(a_pipe[AB-1]) * 34'(b_pipe[AB-1]);
    end

    assign P_i[g] = p_r;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic [16:0] word;
    logic        last;
    logic [16:0] carry;
    int          t;
    int          idx;
  } exp_t;

  exp_t        sb_q[$];
  logic [16:0] m_a = '0;
  logic [16:0] carry_m;
  int          widx;
  logic        prev_issue, prev_first;
  logic [16:0] prev_c;
  int          ctl_words, row_holds, res_total;
  logic [16:0] row_w0, row_wlast, row_carry;

  // Scoreboard monitor, sampled on the falling edge
  initial begin
    exp_t e;
    logic iss;
    logic [33:0] t;
    carry_m = '0; widx = 0; prev_issue = 1'b0; prev_first = 1'b0; prev_c = '0;
    ctl_words = 0; row_holds = 0; res_total = 0;
    row_w0 = '0; row_wlast = '0; row_carry = '0;
    forever begin
      @(negedge clock_i);
      if (reset_i) begin
        sb_q.delete();
        widx = 0; carry_m = '0; prev_issue = 1'b0; ctl_words = 0;
      end else begin
        if (res_valid_o[0] || res_valid_o[1]) begin
          if (sb_q.size() == 0) begin
            chk("spurious_res_valid", 1, 0);
          end else begin
            e = sb_q.pop_front();
            for (int g = 0; g < NI; g++) begin
              chk($sformatf("res_valid[%0d]", g), res_valid_o[g], 1);
              chk($sformatf("res_word[%0d]", g), res_word_o[g], e.word);
              chk($sformatf("res_last[%0d]", g), res_last_o[g], e.last);
              chk($sformatf("res_carry[%0d]", g), res_carry_o[g], e.carry);
              chk($sformatf("done[%0d]", g), done_o[g], e.last);
            end
            chk("res_latency", 64'(cyc - e.t), LAT);
            if (e.idx == 0) row_w0 = res_word_o[0];
            if (e.last) begin
              row_wlast = res_word_o[0];
              row_carry = res_carry_o[0];
            end
            res_total++;
          end
        end
        for (int g = 0; g < NI; g++) begin
          chk($sformatf("creg_en[%0d]", g), CREG_en_o[g], prev_issue);
          if (prev_issue) begin
            chk($sformatf("opmode[%0d]", g), OPMODE_o[g], prev_first ? OP_FIRST : OP_ACC);
            chk($sformatf("c_word[%0d]", g), C_o[g], 34'(prev_c));
          end
        end
        if (OPMODE_o[0] == OP_FIRST) begin
          ctl_words = 1; row_holds = 0;
        end else if (OPMODE_o[0] == OP_ACC) begin
          ctl_words++;
        end else if (OPMODE_o[0] == OP_HOLD && ctl_words > 0 && ctl_words < WC) begin
          row_holds++;
        end
        iss = in_valid_i && in_ready_o[0];
        if (iss) begin
          t = 34'(m_a) * 34'(b_word_i) + 34'(c_word_i) + ((widx == 0) ? 34'd0 : 34'(carry_m));
          e.word  = t[16:0];
          e.last  = (widx == WC - 1);
          e.carry = (widx == WC - 1) ? t[33:17] : 17'd0;
          e.t     = cyc;
          e.idx   = widx;
          sb_q.push_back(e);
          carry_m = t[33:17];
          for (int g = 0; g < NI; g++) begin
            chk($sformatf("A_o[%0d]", g), A_o[g], m_a);
            chk($sformatf("B_o[%0d]", g), B_o[g], b_word_i);
          end
          prev_first = (widx == 0);
          widx = (widx + 1) % WC;
        end
        prev_issue = iss;
        prev_c = c_word_i;
      end
    end
  end

  typedef struct {
    logic [16:0] a, b, c;
    int          stall_after, stall_len;
    logic [16:0] exp_w0, exp_wlast, exp_carry;
  } vec_t;

  vec_t vt [6];

  task automatic check_all_zero(input string tag);
    for (int g = 0; g < NI; g++) begin
      chk({tag, "_in_ready"}, in_ready_o[g], 0);
      chk({tag, "_busy"}, busy_o[g], 0);
      chk({tag, "_done"}, done_o[g], 0);
      chk({tag, "_res_valid"}, res_valid_o[g], 0);
      chk({tag, "_res_word"}, res_word_o[g], 0);
      chk({tag, "_res_last"}, res_last_o[g], 0);
      chk({tag, "_res_carry"}, res_carry_o[g], 0);
      chk({tag, "_A"}, A_o[g], 0);
      chk({tag, "_B"}, B_o[g], 0);
      chk({tag, "_C"}, C_o[g], 0);
      chk({tag, "_opmode"}, OPMODE_o[g], OP_ZERO);
      chk({tag, "_creg_en"}, CREG_en_o[g], 0);
    end
  endtask

  task automatic issue_word(input logic [16:0] b, input logic [16:0] c);
    bit ok = 0;
    in_valid_i = 1'b1;
    b_word_i = b;
    c_word_i = c;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock_i);
      if (in_ready_o[0]) begin
        ok = 1;
        break;
      end
    end
    chk("issue_ready_timeout", 64'(ok), 1);
    @(posedge clock_i); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock_i);
      if (done_o[0]) begin
        got = 1;
        break;
      end
    end
    chk("done_timeout", 64'(got), 1);
  endtask

  task automatic run_row(input vec_t v, input string nm);
    int base;
    base = res_total;
    m_a = v.a;
    a_word_i = v.a;
    start_i = 1'b1;
    @(posedge clock_i); #1;
    start_i = 1'b0;
    for (int w = 0; w < WC; w++) begin
      issue_word(v.b, v.c);
      if (w == v.stall_after) repeat (v.stall_len) begin
        @(posedge clock_i); #1;
      end
    end
    wait_done();
    @(posedge clock_i); #1;
    chk({nm, "_res_count"}, 64'(res_total - base), WC);
    chk({nm, "_word0"}, row_w0, v.exp_w0);
    chk({nm, "_word_last"}, row_wlast, v.exp_wlast);
    chk({nm, "_carry"}, row_carry, v.exp_carry);
    chk({nm, "_hold_slots"}, 64'(row_holds), 64'(v.stall_len));
    chk({nm, "_idle_after"}, busy_o[0], 0);
  endtask

  initial begin
    int base;
    vt[0] = '{17'h1FFFF, 17'h1FFFF, 17'h00000, 99, 0, 17'h00001, 17'h1FFFF, 17'h1FFFE};
    vt[1] = '{17'h1FFFF, 17'h1FFFF, 17'h00000, 1, 2, 17'h00001, 17'h1FFFF, 17'h1FFFE};
    vt[2] = '{17'h00003, 17'h00005, 17'h00007, 99, 0, 17'h00016, 17'h00016, 17'h00000};
    vt[3] = '{17'h00000, 17'h1FFFF, 17'h1FFFF, 99, 0, 17'h1FFFF, 17'h1FFFF, 17'h00000};
    vt[4] = '{17'h00002, 17'h10000, 17'h00000, 2, 1, 17'h00000, 17'h00001, 17'h00001};
    vt[5] = '{17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 0, 3, 17'h00000, 17'h1FFFF, 17'h1FFFF};

    repeat (3) @(posedge clock_i);
    #1 reset_i = 1'b0;
    @(negedge clock_i);
    check_all_zero("reset");
    @(posedge clock_i); #1;

    for (int i = 0; i < 6; i++) run_row(vt[i], $sformatf("row%0d", i));

    // Reset in the middle of a row
    m_a = 17'h1FFFF;
    a_word_i = 17'h1FFFF;
    start_i = 1'b1;
    @(posedge clock_i); #1;
    start_i = 1'b0;
    issue_word(17'h1FFFF, 17'h00000);
    issue_word(17'h1FFFF, 17'h00000);
    reset_i = 1'b1;
    @(posedge clock_i); #1;
    reset_i = 1'b0;
    @(negedge clock_i);
    check_all_zero("midreset");
    base = res_total;
    repeat (8) @(negedge clock_i);
    chk("midreset_no_results", 64'(res_total - base), 0);
    @(posedge clock_i); #1;
    run_row(vt[0], "post_reset_row");

    // start_i held high across a row and into the next
    m_a = 17'h00003;
    a_word_i = 17'h00003;
    start_i = 1'b1;
    base = res_total;
    @(posedge clock_i); #1;
    for (int w = 0; w < WC; w++) issue_word(17'h00005, 17'h00007);
    wait_done();
    @(negedge clock_i);
    chk("held_start_res_count", 64'(res_total - base), WC);
    chk("held_start_idle_busy", busy_o[0], 0);
    chk("held_start_idle_ready", in_ready_o[0], 0);
    chk("held_start_idle_busy1", busy_o[1], 0);
    @(negedge clock_i);
    chk("held_start_restart_busy", busy_o[0], 1);
    chk("held_start_restart_ready", in_ready_o[0], 1);
    @(posedge clock_i); #1;
    start_i = 1'b0;
    base = res_total;
    for (int w = 0; w < WC; w++) issue_word(17'h00005, 17'h00007);
    wait_done();
    @(posedge clock_i); #1;
    chk("held_start_row2_count", 64'(res_total - base), WC);
    chk("held_start_row2_carry", row_carry, 0);
    chk("held_start_row2_word", row_wlast, 17'h00016);
    repeat (4) @(posedge clock_i);
    #1;
    chk("final_queue_empty", 64'(sb_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
